// File: rtl/maxnet_controller.sv
// Sequencer for the Maxnet winner-take-all datapath: load, row-by-row MAC passes,
// commit, and a convergence/timeout check. Reports the winner index and a timeout flag.
module maxnet_controller #(
  parameter int N        = 4,
  parameter int RW       = 2,
  parameter int IW       = 4,
  parameter int ITER_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  nz_flags,
  output logic          ld_init,
  output logic [RW-1:0] row_sel,
  output logic [N-1:0]  new_en,
  output logic          commit,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] winner,
  output logic          winner_valid,
  output logic          timeout,
  output logic [IW-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_COMPUTE, S_COMMIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   j_q, j_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [RW-1:0]   win_q, win_d;
  logic            wv_q, wv_d;
  logic            to_q, to_d;

  function automatic int unsigned popcnt(input logic [N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic logic [RW-1:0] lowest(input logic [N-1:0] v);
    logic [RW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) idx = RW'(i);
    return idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      iter_q  <= '0;
      win_q   <= '0;
      wv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      iter_q  <= iter_d;
      win_q   <= win_d;
      wv_q    <= wv_d;
      to_q    <= to_d;
    end
  end

  // Result flags are latched on the CHECK->DONE edge so they are already valid
  // while done is high, and then hold until the next accepted start.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    iter_d  = iter_q;
    win_d   = win_q;
    wv_d    = wv_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        iter_d  = '0;
        win_d   = '0;
        wv_d    = 1'b0;
        to_d    = 1'b0;
      end
      S_LOAD: state_d = S_CHECK;
      S_CHECK: begin
        if (popcnt(nz_flags) <= 1) begin
          state_d = S_DONE;
          win_d   = lowest(nz_flags);
          wv_d    = (popcnt(nz_flags) == 1);
        end else if (iter_q == IW'(ITER_MAX)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          state_d = S_COMPUTE;
          j_d     = '0;
        end
      end
      S_COMPUTE: begin
        if (j_q == RW'(N - 1)) state_d = S_COMMIT;
        else                   j_d     = j_q + 1'b1;
      end
      S_COMMIT: begin
        state_d = S_CHECK;
        if (iter_q != IW'(ITER_MAX)) iter_d = iter_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_init      = (state_q == S_LOAD);
  assign row_sel      = (state_q == S_COMPUTE) ? j_q : '0;
  assign new_en       = (state_q == S_COMPUTE) ? ({{(N-1){1'b0}}, 1'b1} << j_q) : '0;
  assign commit       = (state_q == S_COMMIT);
  assign busy         = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                        (state_q == S_COMPUTE) || (state_q == S_COMMIT);
  assign done         = (state_q == S_DONE);
  assign winner       = win_q;
  assign winner_valid = wv_q;
  assign timeout      = to_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller: directed runs push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_maxnet_controller;
  localparam int N = 4, RW = 2, IW = 4;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N-1:0]  nz_flags = '0;
  logic          ld_init, commit, busy, done, winner_valid, timeout;
  logic [RW-1:0] row_sel, winner;
  logic [N-1:0]  new_en;
  logic [IW-1:0] iter_count;

  maxnet_controller #(.N(N), .RW(RW), .IW(IW), .ITER_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .nz_flags(nz_flags),
    .ld_init(ld_init), .row_sel(row_sel), .new_en(new_en), .commit(commit),
    .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
    .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int win; int wv; int to; int iter; int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ld_init || new_en != '0 || commit)
        chk("strobe_excl", int'(ld_init) + $countones(new_en) + int'(commit), 1);
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at rel cycle %0d", cyc - t0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc - t0, e.cyc);
          chk("winner", int'(winner), e.win);
          chk("winner_valid", int'(winner_valid), e.wv);
          chk("timeout", int'(timeout), e.to);
          chk("iter_count", int'(iter_count), e.iter);
          chk("busy_in_done", int'(busy), 0);
        end
      end
    end
  end

  // nz_a holds until the first commit, nz_b afterwards.
  task automatic run(input logic [N-1:0] nz_a, input logic [N-1:0] nz_b,
                     input bit repulse, input bit chk_rows, input bit chk_quiet,
                     input exp_t e);
    int c; bit seen_commit; bit got_done; int strobes;
    c = 0; seen_commit = 0; got_done = 0; strobes = 0;
    sb.push_back(e);
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1; nz_flags = nz_a;
    while (!got_done && c < 200) begin
      @(negedge clk);
      if (chk_rows && c >= 3 && c <= 6) begin
        chk("row_sel", int'(row_sel), c - 3);
        chk("new_en", int'(new_en), 1 << (c - 3));
      end
      if (chk_rows && c == 7) chk("commit_at_7", int'(commit), 1);
      if (new_en != '0 || commit) strobes++;
      if (commit) seen_commit = 1;
      if (done) got_done = 1;
      @(posedge clk); #1;
      c++;
      start = repulse && (c == 4 || c == 8);
      if (seen_commit) nz_flags = nz_b;
    end
    start = 1'b0;
    if (!got_done) begin
      checks++; errors++;
      $display("FAIL run_timeout: no done within %0d cycles", c);
    end
    if (chk_quiet) chk("no_compute_strobes", strobes, 0);
    @(negedge clk);
    chk("hold_done_low", int'(done), 0);
    chk("hold_winner", int'(winner), e.win);
    chk("hold_iter", int'(iter_count), e.iter);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_outs", int'({ld_init, row_sel, new_en, commit, winner, winner_valid, timeout, iter_count}), 0);
    @(negedge clk); rst = 1'b0;

    // single survivor immediately after load
    run(4'b0100, 4'b0100, 0, 0, 1, '{win:2, wv:1, to:0, iter:0, cyc:3});
    // one pass then neuron 1 survives
    run(4'b1111, 4'b0010, 0, 1, 0, '{win:1, wv:1, to:0, iter:1, cyc:9});
    // two neurons stuck -> iteration cap
    run(4'b0011, 4'b0011, 0, 0, 0, '{win:0, wv:0, to:1, iter:15, cyc:93});
    // everyone decays together
    run(4'b1111, 4'b0000, 0, 0, 0, '{win:0, wv:0, to:0, iter:1, cyc:9});

    // reset mid-COMPUTE
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1; nz_flags = 4'b1111;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_new_en", int'(new_en), 0);
    chk("arst_row_sel", int'(row_sel), 0);
    chk("arst_outs", int'({ld_init, commit, done, winner, winner_valid, timeout, iter_count}), 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("no_done_after_rst", sb.size(), 0);
    run(4'b0100, 4'b0100, 0, 0, 1, '{win:2, wv:1, to:0, iter:0, cyc:3});

    // start re-pulsed mid-run is ignored
    run(4'b1111, 4'b0010, 1, 1, 0, '{win:1, wv:1, to:0, iter:1, cyc:9});

    repeat (5) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
